pwm_compare_stage: RTL and testbench

- Downstream consumer of the modulus counter's count value and final value; converts the running count into a PWM waveform.
- Holds a double-buffered duty value. A new duty is written via a valid/ready handshake into a shadow register and becomes active only at the period boundary, so no glitched periods occur.
- Also emits a one-cycle period tick per wrap.
- Sits between the modulus counter and the PWM output pins / interrupt logic.

---
 rtl/pwm_compare_stage.sv | 64 ++++++
 tb/tb_pwm_compare_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: turns a modulus counter's count into a PWM waveform, with a
// double-buffered duty value. Define PWM_PERIOD_COUNT_EN to add the 16-bit period_count output.
module pwm_compare_stage #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            count_en,
  input  logic [BITS-1:0] count_in,
  input  logic [BITS-1:0] period_in,
  input  logic [BITS-1:0] duty_data,
  input  logic            duty_valid,
  output logic            duty_ready,
  output logic            pwm_out,
  output logic            period_tick,
  output logic [BITS-1:0] duty_active
`ifdef PWM_PERIOD_COUNT_EN
  ,
  output logic [15:0]     period_count
`endif
);

  logic [BITS-1:0] shadow;
  logic            shadow_full;
  logic            wrap;
  logic            xfer;

  // Ready also drops while reset is asserted, so a write offered during reset is never taken.
  assign duty_ready = !shadow_full && !reset;
  assign xfer       = duty_valid && duty_ready;
  assign wrap       = count_en && (count_in == period_in);

  // NOTE: non-blocking assignments throughout this block. The compare must see the
  // duty_active value from before this edge, even though the same edge may reload it.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_active <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      // A transfer can only happen while shadow is empty, so these branches never collide.
      if (wrap && shadow_full) begin
        duty_active <= shadow;
        shadow_full <= 1'b0;
      end else if (xfer) begin
        shadow      <= duty_data;
        shadow_full <= 1'b1;
      end

      if (count_en) pwm_out <= (count_in < duty_active);
      period_tick <= wrap;
    end
  end

`ifdef PWM_PERIOD_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)     period_count <= '0;
    else if (wrap) period_count <= period_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Self-checking bench for pwm_compare_stage: directed scenarios plus randomized traffic
// compared against a behavioural model built around a pending-duty queue.
module tb_pwm_compare_stage;
  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            count_en = 1'b0;
  logic [BITS-1:0] count_in = '0;
  logic [BITS-1:0] period_in = 4'd9;
  logic [BITS-1:0] duty_data = '0;
  logic            duty_valid = 1'b0;
  logic            duty_ready;
  logic            pwm_out;
  logic            period_tick;
  logic [BITS-1:0] duty_active;
`ifdef PWM_PERIOD_COUNT_EN
  logic [15:0]     period_count;
`endif

  pwm_compare_stage #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .count_en(count_en), .count_in(count_in),
    .period_in(period_in), .duty_data(duty_data), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .pwm_out(pwm_out), .period_tick(period_tick),
    .duty_active(duty_active)
`ifdef PWM_PERIOD_COUNT_EN
    , .period_count(period_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: a duty write waits in a queue (depth <= 1) until the next wrap.
  logic [BITS-1:0] m_active = '0;
  logic [BITS-1:0] m_pending[$];
  logic            m_pwm = 1'b0;
  logic            m_tick = 1'b0;
  logic            m_xfer = 1'b0;
  logic [15:0]     m_pcount = '0;
  logic [BITS-1:0] cnt = '0;      // emulated upstream modulus counter

  function automatic logic [BITS+2:0] exp_vec();
    return {m_pwm, m_tick, m_active, (m_pending.size() == 0) && !reset};
  endfunction

  task automatic model_edge();
    logic rdy, wrp;
    rdy    = (m_pending.size() == 0) && !reset;
    wrp    = count_en && (count_in == period_in);
    m_xfer = duty_valid && rdy;
    if (reset) begin
      m_active = '0; m_pwm = 1'b0; m_tick = 1'b0; m_pcount = '0;
      m_pending.delete();
    end else begin
      if (count_en) m_pwm = (count_in < m_active);
      if (wrp && m_pending.size() != 0) m_active = m_pending.pop_front();
      else if (m_xfer) m_pending.push_back(duty_data);
      m_tick = wrp;
      if (wrp) m_pcount = m_pcount + 16'd1;
    end
  endtask

  // One clock: drive inputs, take the edge, update model and counter, settle 1ns.
  task automatic cycle(input logic v, input logic [BITS-1:0] d);
    duty_valid = v;
    duty_data  = d;
    count_in   = cnt;
    @(posedge clk);
    model_edge();
    if (reset) cnt = '0;
    else if (count_en) cnt = (cnt == period_in) ? '0 : cnt + 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; count_en = 1'b1;
    cycle(1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic run_to_wrap();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      hit = count_en && (cnt == period_in);
      cycle(1'b0, '0);
    end
    if (!hit) begin
      n_checks++; n_err++;
      $display("FAIL run_to_wrap: no wrap seen within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; count_en = 1'b1; period_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd9);
      n_checks++;
      if ({pwm_out, period_tick, duty_active, duty_ready} !== 7'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b want 0000000", i, {pwm_out, period_tick, duty_active, duty_ready});
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (duty_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", duty_ready);
    end
    duty_valid = 1'b0;
    run_to_wrap();
    run_to_wrap();
    n_checks++;
    if (duty_active !== 4'd0) begin
      n_err++; $display("FAIL reset_no_xfer: duty_active got %0d want 0", duty_active);
    end
  endtask

  task automatic test_basic();
    int highs, ticks;
    logic [BITS-1:0] c;
    do_reset();
    period_in = 4'd9;
    cycle(1'b1, 4'd3);
    run_to_wrap();
    n_checks++;
    if (duty_active !== 4'd3) begin
      n_err++; $display("FAIL basic_active: got %0d want 3", duty_active);
    end
    highs = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      c = cnt;
      cycle(1'b0, '0);
      highs += int'(pwm_out);
      ticks += int'(period_tick);
      n_checks++;
      if (pwm_out !== (c < 4'd3)) begin
        n_err++; $display("FAIL basic_pwm count=%0d: got %b want %b", c, pwm_out, c < 4'd3);
      end
    end
    n_checks++;
    if (highs != 3 || ticks != 1) begin
      n_err++; $display("FAIL basic_period: highs=%0d ticks=%0d want 3 and 1", highs, ticks);
    end
  endtask

  task automatic test_holdoff();
    int guard;
    do_reset();
    period_in = 4'd9;
    while (cnt != 4'd4) cycle(1'b0, '0);
    cycle(1'b1, 4'd5);
    guard = 0;
    while (cnt != 4'd9) begin
      cycle(1'b1, 4'd7);
      guard++;
      n_checks++;
      if (duty_ready !== 1'b0 || m_xfer) begin
        n_err++; $display("FAIL holdoff_ready: got %b want 0", duty_ready);
      end
    end
    cycle(1'b1, 4'd7);  // wrap edge: shadow 5 applied
    n_checks++;
    if (duty_active !== 4'd5 || duty_ready !== 1'b1) begin
      n_err++; $display("FAIL holdoff_apply: active=%0d ready=%b want 5 and 1", duty_active, duty_ready);
    end
    cycle(1'b1, 4'd7);
    n_checks++;
    if (!m_xfer || duty_ready !== 1'b0) begin
      n_err++; $display("FAIL holdoff_accept7: ready=%b want 0 after transfer", duty_ready);
    end
    run_to_wrap();
    n_checks++;
    if (duty_active !== 4'd7) begin
      n_err++; $display("FAIL holdoff_active7: got %0d want 7", duty_active);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    period_in = 4'd9;
    while (cnt != 4'd9) cycle(1'b0, '0);
    cycle(1'b1, 4'd4);
    n_checks++;
    if (duty_active !== 4'd0 || period_tick !== 1'b1) begin
      n_err++; $display("FAIL simul_wrap: active=%0d tick=%b want 0 and 1", duty_active, period_tick);
    end
    run_to_wrap();
    n_checks++;
    if (duty_active !== 4'd4) begin
      n_err++; $display("FAIL simul_next: got %0d want 4", duty_active);
    end
  endtask

  task automatic test_extremes();
    logic            p;
    logic [BITS-1:0] a;
    do_reset();
    period_in = 4'd9;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0);
      n_checks++;
      if (pwm_out !== 1'b0) begin n_err++; $display("FAIL duty0[%0d]: got %b want 0", i, pwm_out); end
    end
    cycle(1'b1, 4'd15);
    run_to_wrap();
    cycle(1'b0, '0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0);
      n_checks++;
      if (pwm_out !== 1'b1) begin n_err++; $display("FAIL duty15[%0d]: got %b want 1", i, pwm_out); end
    end
    cycle(1'b1, 4'd3);
    run_to_wrap();
    while (cnt != 4'd3) cycle(1'b0, '0);
    p = pwm_out; a = duty_active;
    count_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0);
      n_checks++;
      if (pwm_out !== 1'b1 || duty_active !== 4'd3 || period_tick !== 1'b0 || pwm_out !== p || duty_active !== a) begin
        n_err++; $display("FAIL freeze[%0d]: pwm=%b active=%0d tick=%b want 1 3 0", i, pwm_out, duty_active, period_tick);
      end
    end
    count_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, '0);
      n_checks++;
      if ({pwm_out, period_tick, duty_active, duty_ready} !== exp_vec()) begin
        n_err++; $display("FAIL resume[%0d]: got %b want %b", i, {pwm_out, period_tick, duty_active, duty_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_period_zero();
    do_reset();
    period_in = 4'd0;
    cycle(1'b1, 4'd6);
    n_checks++;
    if (period_tick !== 1'b1 || duty_active !== 4'd0) begin
      n_err++; $display("FAIL p0_first: tick=%b active=%0d want 1 and 0", period_tick, duty_active);
    end
    cycle(1'b0, '0);
    n_checks++;
    if (period_tick !== 1'b1 || duty_active !== 4'd6) begin
      n_err++; $display("FAIL p0_apply: tick=%b active=%0d want 1 and 6", period_tick, duty_active);
    end
    cycle(1'b0, '0);
    n_checks++;
    if (period_tick !== 1'b1 || pwm_out !== 1'b1) begin
      n_err++; $display("FAIL p0_run: tick=%b pwm=%b want 1 and 1", period_tick, pwm_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      count_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) period_in = BITS'($urandom_range(0, 15));
      cycle($urandom_range(0, 2) == 0, BITS'($urandom));
      n_checks++;
      if ({pwm_out, period_tick, duty_active, duty_ready} !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %b want %b", i, {pwm_out, period_tick, duty_active, duty_ready}, exp_vec());
      end
`ifdef PWM_PERIOD_COUNT_EN
      n_checks++;
      if (period_count !== m_pcount) begin
        n_err++; $display("FAIL random_pcount[%0d]: got %0d want %0d", i, period_count, m_pcount);
      end
`endif
    end
    reset = 1'b0; count_en = 1'b1;
  endtask

`ifdef PWM_PERIOD_COUNT_EN
  task automatic test_period_count();
    do_reset();
    period_in = 4'd9;
    for (int i = 0; i < 3; i++) run_to_wrap();
    n_checks++;
    if (period_count !== 16'd3) begin
      n_err++; $display("FAIL pcount3: got %0d want 3", period_count);
    end
    do_reset();
    period_in = 4'd0;
    for (int i = 0; i < 65535; i++) cycle(1'b0, '0);
    n_checks++;
    if (period_count !== 16'hFFFF) begin
      n_err++; $display("FAIL pcount_max: got %h want ffff", period_count);
    end
    cycle(1'b0, '0);
    n_checks++;
    if (period_count !== 16'h0000) begin
      n_err++; $display("FAIL pcount_roll: got %h want 0000", period_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_holdoff();
    test_simultaneous();
    test_extremes();
    test_period_zero();
    test_random();
`ifdef PWM_PERIOD_COUNT_EN
    test_period_count();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
